// File: rtl/frame_writer.sv
// frame_writer: write-side master for the framebuffer RAM.
// Streams pixel words into sequential addresses while a frame load is in progress.
module frame_writer #(
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 32,
   parameter int BASE_ADDR = 0,
   parameter int NUM_WORDS = 10000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              hold,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   output logic              mem_sel,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] word_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_FLUSH
   } state_t;

   localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] L_ONE  = ADDR_W'(1);

   state_t            r_state;
   state_t            w_state_nx;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_nx;
   logic [ADDR_W-1:0] r_count;
   logic [ADDR_W-1:0] w_count_nx;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] w_data_nx;
   logic              r_wren;
   logic              w_wren_nx;
   logic              r_sel;
   logic              w_sel_nx;
   logic              r_busy;
   logic              w_busy_nx;
   logic              r_done;
   logic              w_done_nx;
   logic              w_accept;

   // abort outranks a word offered in the same cycle, so it gates ready
   assign in_ready = (r_state == S_WRITE) & ~hold & ~abort;
   assign w_accept = in_valid & in_ready;

   assign mem_addr   = 32'(r_addr);
   assign mem_data   = r_data;
   assign mem_wren   = r_wren;
   assign mem_sel    = r_sel;
   assign busy       = r_busy;
   assign done       = r_done;
   assign word_count = r_count;

   // Next-state and next-output decode; write strobe and done are single-cycle
   always_comb begin
      w_state_nx = r_state;
      w_addr_nx  = r_addr;
      w_data_nx  = r_data;
      w_count_nx = r_count;
      w_sel_nx   = r_sel;
      w_busy_nx  = r_busy;
      w_wren_nx  = 1'b0;
      w_done_nx  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nx = S_WRITE;
               w_count_nx = '0;
               w_sel_nx   = 1'b1;
               w_busy_nx  = 1'b1;
            end
         end
         S_WRITE: begin
            if (abort) begin
               w_state_nx = S_IDLE;
               w_sel_nx   = 1'b0;
               w_busy_nx  = 1'b0;
            end else if (w_accept) begin
               w_addr_nx  = L_BASE + r_count;
               w_data_nx  = in_data;
               w_wren_nx  = 1'b1;
               w_count_nx = r_count + L_ONE;
               if (r_count == L_LAST) begin
                  w_state_nx = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            w_state_nx = S_IDLE;
            w_sel_nx   = 1'b0;
            w_busy_nx  = 1'b0;
            w_done_nx  = 1'b1;
         end
         default: begin
            w_state_nx = S_IDLE;
            w_sel_nx   = 1'b0;
            w_busy_nx  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any partial frame
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_data  <= '0;
         r_count <= '0;
         r_wren  <= 1'b0;
         r_sel   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_addr  <= w_addr_nx;
         r_data  <= w_data_nx;
         r_count <= w_count_nx;
         r_wren  <= w_wren_nx;
         r_sel   <= w_sel_nx;
         r_busy  <= w_busy_nx;
         r_done  <= w_done_nx;
      end
   end

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: scoreboard bench for frame_writer.
// Driver predicts writes into a queue; a negedge monitor pops and compares.
module tb_frame_writer;

   localparam int AW   = 15;
   localparam int DW   = 32;
   localparam int BASE = 100;
   localparam int NW   = 4;

   logic          clk      = 1'b0;
   logic          rst      = 1'b0;
   logic          start    = 1'b0;
   logic          abort    = 1'b0;
   logic          hold     = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data  = '0;
   logic          in_ready;
   logic [31:0]   mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_wren;
   logic          mem_sel;
   logic          busy;
   logic          done;
   logic [AW-1:0] word_count;

   frame_writer #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .BASE_ADDR(BASE),
      .NUM_WORDS(NW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .abort(abort),
      .hold(hold),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .mem_addr(mem_addr),
      .mem_data(mem_data),
      .mem_wren(mem_wren),
      .mem_sel(mem_sel),
      .busy(busy),
      .done(done),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]   addr;
      logic [DW-1:0] data;
      bit            last;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   m_phase = 0;   // 0 idle, 1 taking words, 2 last write draining
   int   m_count = 0;
   bit   mon_en = 0;
   bit   pend_done = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every presented write must match the oldest prediction
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         chk("done", done, pend_done);
         pend_done = 0;
         if (mem_wren) begin
            if (q.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               e = q.pop_front();
               chk("mem_addr", mem_addr, e.addr);
               chk("mem_data", mem_data, e.data);
               chk("mem_sel_on_write", mem_sel, 1);
               if (e.last) pend_done = 1;
            end
         end
      end
   end

   // One clock of stimulus plus the reference model's view of that edge
   task automatic step(bit s, bit a, bit h, bit v, logic [DW-1:0] d, bit r = 1'b1);
      exp_t e;
      start    = s;
      abort    = a;
      hold     = h;
      in_valid = v;
      in_data  = d;
      rst      = r;
      #1;
      chk("in_ready", in_ready, (m_phase == 1 && !h && !a));
      if (!r) begin
         m_phase = 0;
         m_count = 0;
      end else begin
         case (m_phase)
            0: if (s) begin
               m_phase = 1;
               m_count = 0;
            end
            1: if (a) begin
               m_phase = 0;
            end else if (v && !h) begin
               e.addr = 32'(BASE + m_count);
               e.data = d;
               e.last = (m_count == NW - 1);
               q.push_back(e);
               m_count++;
               if (m_count == NW) m_phase = 2;
            end
            default: m_phase = 0;
         endcase
      end
      @(posedge clk);
      #2;
      chk("busy", busy, m_phase != 0);
      chk("mem_sel", mem_sel, m_phase != 0);
      chk("word_count", word_count, m_count);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0);
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b1;
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_addr", mem_addr, 0);
      chk("rst_data", mem_data, 0);
      chk("rst_wren", mem_wren, 0);
      chk("rst_sel", mem_sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", word_count, 0);
      chk("rst_ready", in_ready, 0);
      mon_en = 1;

      // nominal frame
      step(1, 0, 0, 0, '0);
      for (int i = 0; i < NW; i++) step(0, 0, 0, 1, 32'hA0 + i);
      idle(3);
      chk("nominal_count", word_count, NW);

      // backpressure mid-frame
      step(1, 0, 0, 0, '0);
      step(0, 0, 0, 1, 32'hB0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'hB1);
      for (int i = 1; i < NW; i++) step(0, 0, 0, 1, 32'hB0 + i);
      idle(3);

      // gapped source
      step(1, 0, 0, 0, '0);
      for (int i = 0; i < 2 * NW; i++) step(0, 0, 0, (i % 2) == 0, 32'hC0 + i / 2);
      idle(3);

      // abort on the third word, then a clean restart
      step(1, 0, 0, 0, '0);
      step(0, 0, 0, 1, 32'hD0);
      step(0, 0, 0, 1, 32'hD1);
      step(0, 1, 0, 1, 32'hD2);
      idle(2);
      chk("abort_count", word_count, 2);
      step(1, 0, 0, 0, '0);
      for (int i = 0; i < NW; i++) step(0, 0, 0, 1, 32'hD8 + i);
      idle(3);

      // reset mid-frame, then a clean restart
      step(1, 0, 0, 0, '0);
      step(0, 0, 0, 1, 32'hE0);
      step(0, 0, 0, 1, 32'hE1);
      step(0, 0, 0, 1, 32'hE2, 1'b0);
      idle(1);
      chk("midrst_count", word_count, 0);
      step(1, 0, 0, 0, '0);
      for (int i = 0; i < NW; i++) step(0, 0, 0, 1, 32'hE8 + i);
      idle(3);

      // randomized traffic with stray start/abort/hold
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 3) == 0,
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) != 0,
              $urandom);
      end
      idle(4);
      chk("queue_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Write-side master for the 32-bit framebuffer RAM (15-bit word address) that the VGA path reads.
- Accepts a stream of pixel words over a valid/ready handshake.
- Generates sequential write addresses from BASE_ADDR and drives the RAM data, write-enable and address-select inputs.
- Owns the RAM port only while a frame load is in progress. Otherwise the VGA read-address counter keeps the port.

Parameters:
- ADDR_W, 15, RAM word-address width.
- DATA_W, 32, RAM data width.
- BASE_ADDR, 0, first word address written for a frame.
- NUM_WORDS, 10000, words per frame (100x100 image). Legal range 1..2^ADDR_W-BASE_ADDR.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-low.
- start  input  1  one-cycle request to load a frame. Honoured only in IDLE.
- abort  input  1  cancel the load in progress.
- hold  input  1  VGA needs the port. Stall acceptance while high.
- in_data  input  DATA_W  pixel word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  writer accepts in_data this cycle.
- mem_addr  output  32  write address, zero-extended from ADDR_W bits. Feeds the processor-side address input of the RAM mux.
- mem_data  output  DATA_W  RAM write data.
- mem_wren  output  1  RAM write enable.
- mem_sel  output  1  1 = RAM address mux selects mem_addr. 0 = VGA read address.
- busy  output  1  frame load in progress.
- done  output  1  one-cycle pulse when the last word has been written.
- word_count  output  ADDR_W  words accepted in the current or last frame.

Behaviour:
- Reset (rst=0 at a clk edge) drives all outputs to 0, sets word_count=0 and state=IDLE. This applies in any state, including mid-frame: a partial write sequence is abandoned and the write in flight is dropped.
- All outputs are registered except in_ready, which is combinational: in_ready = (state==WRITE) & ~hold & ~abort.
- FSM IDLE:
  - start=1 -> WRITE; word_count<=0; mem_sel<=1; busy<=1.
  - Otherwise stay in IDLE.
- FSM WRITE:
  - Acceptance occurs when in_valid & in_ready.
  - On acceptance, on the next edge: mem_addr<=BASE_ADDR+word_count, mem_data<=in_data, mem_wren<=1, word_count<=word_count+1.
  - With no acceptance, mem_wren<=0 and mem_addr/mem_data hold their values.
  - Write latency is 1 cycle from acceptance to mem_wren high. Back-to-back acceptance gives one write per cycle.
  - When the accepted word is number NUM_WORDS (word_count==NUM_WORDS-1 at acceptance) -> FLUSH.
  - abort=1 -> IDLE next edge. mem_wren<=0, mem_sel<=0, busy<=0, no done. word_count keeps the partial value. abort has priority over acceptance in the same cycle: that word is not accepted.
  - start in WRITE is ignored.
- FSM FLUSH:
  - Lasts 1 cycle, during which the final mem_wren=1 is presented with mem_sel still 1.
  - Next edge: mem_wren<=0, mem_sel<=0, busy<=0, done<=1 -> IDLE.
  - abort during FLUSH is ignored because the final write is already committed.
- done is high for exactly one cycle, the first cycle back in IDLE.
- hold:
  - hold is sampled combinationally into in_ready only.
  - A write already registered (mem_wren=1) still completes while hold rises; the VGA side tolerates one cycle of lost reads.
  - mem_sel stays 1 during hold. Releasing the port is the responsibility of the system mux arbitration, which gives hold priority.
- Address arithmetic is ADDR_W bits. BASE_ADDR+NUM_WORDS never exceeds 2^ADDR_W by the parameter constraint, so there is no wrap. Upper 32-ADDR_W bits of mem_addr are always 0.
- word_count saturates at NUM_WORDS. It is not cleared on done, only on the next start or on reset.
- Simultaneous start and abort in IDLE: start wins, abort has no effect in IDLE.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 and start=1 -> all outputs 0, in_ready=0, state IDLE.
- Nominal frame (NUM_WORDS=4, BASE_ADDR=100): start, then 4 consecutive valid words 0xA0..0xA3 -> mem_wren high 4 consecutive cycles at addresses 100..103 with matching data. mem_sel 1 from the cycle after start through the last write. done pulses once, 1 cycle after the last mem_wren. word_count=4.
- Backpressure: hold=1 for 3 cycles mid-frame with in_valid=1 -> in_ready=0, no mem_wren, no address advance. Frame completes with 4 writes and no duplicates or skips.
- Gapped source: in_valid toggling 1,0,1,0 -> writes only on accepted cycles, addresses strictly sequential.
- Abort: abort asserted in the same cycle as the 3rd valid word -> only 2 writes (addresses 100,101), no done, busy and mem_sel drop next cycle, word_count=2. A subsequent start restarts at address 100.
- Reset mid-frame after 2 writes -> outputs cleared next edge. A new start writes from BASE_ADDR with word_count counting from 0.
